pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_ras.sv | 85 ++++++++
 rtl/pc_sequencer.sv | 124 ++++++++++++
 tb/tb_pc_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and default vectors for the PC sequencer slice.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_JMP  = 3'd2,
    SEL_RAS  = 3'd3,
    SEL_EXC  = 3'd4,
    SEL_HOLD = 3'd5
  } pc_sel_e;

  localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VEC_DEF   = 32'h8000_0180;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry,
// and push+pop together rewrites the top without changing occupancy.
module pc_ras
  import pc_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] SP_ONE   = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_ZERO = (PW+1)'(0);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]   sp_q, sp_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic [PW-1:0]   top_idx_s;
  logic [PW-1:0]   wr_idx_s;
  logic            wr_en_s;

  assign top_idx_s = sp_q - SP_ONE;
  assign top_o     = mem_q[top_idx_s];
  assign empty_o   = (cnt_q == CNT_ZERO);
  assign full_o    = (cnt_q == CNT_FULL);

  // Next stack pointer, occupancy and write port.
  always_comb begin
    sp_d     = sp_q;
    cnt_d    = cnt_q;
    wr_en_s  = 1'b0;
    wr_idx_s = sp_q;
    if (push_i && pop_i) begin
      wr_en_s  = 1'b1;
      wr_idx_s = top_idx_s;
    end else if (push_i) begin
      wr_en_s = 1'b1;
      sp_d    = sp_q + SP_ONE;
      if (cnt_q != CNT_FULL) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else if (pop_i) begin
      if (cnt_q != CNT_ZERO) begin
        sp_d  = sp_q - SP_ONE;
        cnt_d = cnt_q - CNT_ONE;
      end else begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
      end
    end else begin
      sp_d  = sp_q;
      cnt_d = cnt_q;
    end
  end

  // Stack state; reset discards every stored return address.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      if (wr_en_s) begin
        mem_q[wr_idx_s] <= data_i;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with exception redirect and optional return-address
// stack, built only when PC_SEQUENCER_RAS_EN is defined.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = PC_RESET_VEC_DEF,
  parameter logic [XLEN-1:0] EXC_VEC   = PC_EXC_VEC_DEF,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            PCWrite,
  input  logic            BranchTaken,
  input  logic [XLEN-1:0] BranchTarget,
  input  logic            Jump,
  input  logic [XLEN-1:0] JumpTarget,
  input  logic            JumpLink,
  input  logic            Return,
  input  logic            Exception,
  output logic [XLEN-1:0] PCResult,
  output logic [XLEN-1:0] PCPlus4,
  output logic [XLEN-1:0] EPC,
  output logic            RasEmpty,
  output logic            RasFull
);

  localparam logic [XLEN-1:0] FOUR       = XLEN'(4);
  localparam logic [XLEN-1:0] EIGHT      = XLEN'(8);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] ras_top_s;
  logic            ras_hit_s;
  pc_sel_e         sel_s;

  assign PCResult = pc_q;
  assign PCPlus4  = pc_q + FOUR;
  assign EPC      = epc_q;

`ifdef PC_SEQUENCER_RAS_EN
  logic ras_op_s, ras_push_s, ras_pop_s, ras_empty_s, ras_full_s;

  assign ras_op_s   = Jump && PCWrite && !Exception && !BranchTaken;
  assign ras_push_s = ras_op_s && JumpLink;
  assign ras_pop_s  = ras_op_s && Return;
  assign ras_hit_s  = Return && !ras_empty_s;
  assign RasEmpty   = ras_empty_s;
  assign RasFull    = ras_full_s;

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .Clk     (Clk),
    .Reset   (Reset),
    .push_i  (ras_push_s),
    .pop_i   (ras_pop_s),
    .data_i  (pc_q + EIGHT),
    .top_o   (ras_top_s),
    .empty_o (ras_empty_s),
    .full_o  (ras_full_s)
  );
`else
  logic unused_ras_ctl_s;

  assign unused_ras_ctl_s = &{1'b0, JumpLink, Return};
  assign ras_hit_s        = 1'b0;
  assign ras_top_s        = '0;
  assign RasEmpty         = 1'b1;
  assign RasFull          = 1'b0;
`endif

  // Fixed-priority next-PC source.
  always_comb begin
    sel_s = SEL_SEQ;
    if (Exception) begin
      sel_s = SEL_EXC;
    end else if (!PCWrite) begin
      sel_s = SEL_HOLD;
    end else if (BranchTaken) begin
      sel_s = SEL_BR;
    end else if (Jump) begin
      if (ras_hit_s) begin
        sel_s = SEL_RAS;
      end else begin
        sel_s = SEL_JMP;
      end
    end else begin
      sel_s = SEL_SEQ;
    end
  end

  // Next PC and EPC values; every loaded target is word-aligned.
  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
    case (sel_s)
      SEL_EXC: begin
        pc_d  = EXC_VEC;
        epc_d = pc_q;
      end
      SEL_HOLD: pc_d = pc_q;
      SEL_BR:   pc_d = BranchTarget & ALIGN_MASK;
      SEL_JMP:  pc_d = JumpTarget & ALIGN_MASK;
      SEL_RAS:  pc_d = ras_top_s & ALIGN_MASK;
      SEL_SEQ:  pc_d = pc_q + FOUR;
      default:  pc_d = pc_q;
    endcase
  end

  // PC and EPC registers; reset overrides every input.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q  <= RESET_VEC;
      epc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; expectations follow the build's
// PC_SEQUENCER_RAS_EN setting.
module tb_pc_sequencer;

`ifdef PC_SEQUENCER_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset, PCWrite, BranchTaken, Jump, JumpLink, Return, Exception;
  logic [31:0] BranchTarget, JumpTarget;
  logic [31:0] PCResult, PCPlus4, EPC;
  logic        RasEmpty, RasFull;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PCWrite      (PCWrite),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .JumpLink     (JumpLink),
    .Return       (Return),
    .Exception    (Exception),
    .PCResult     (PCResult),
    .PCPlus4      (PCPlus4),
    .EPC          (EPC),
    .RasEmpty     (RasEmpty),
    .RasFull      (RasFull)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic e, input logic f);
    chk({tag, "_empty"}, {31'd0, RasEmpty}, {31'd0, e});
    chk({tag, "_full"},  {31'd0, RasFull},  {31'd0, f});
  endtask

  task automatic set_ctl(input logic pw, input logic br, input logic j,
                         input logic jl, input logic ret, input logic exc);
    PCWrite = pw; BranchTaken = br; Jump = j; JumpLink = jl; Return = ret; Exception = exc;
  endtask

  initial begin
    logic [31:0] call_pc [5];
    logic [31:0] exp_pc;

    Reset = 1'b1; BranchTarget = 32'h0; JumpTarget = 32'h0;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("rst_pc", PCResult, 32'h0000_0000);
    chk("rst_epc", EPC, 32'h0000_0000);
    chk("rst_plus4", PCPlus4, 32'h0000_0004);
    chk_flags("rst", 1'b1, 1'b0);

    // sequential fetch
    Reset = 1'b0;
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk("seq1", PCResult, 32'h0000_0004);
    step(); chk("seq2", PCResult, 32'h0000_0008);
    step(); chk("seq3", PCResult, 32'h0000_000C);
    step(); chk("seq4", PCResult, 32'h0000_0010);

    // stall with a pending branch, then release
    BranchTarget = 32'h0000_0040;
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk("hold1", PCResult, 32'h0000_0010);
    step(); chk("hold2", PCResult, 32'h0000_0010);
    PCWrite = 1'b1;
    step(); chk("br_release", PCResult, 32'h0000_0040);

    // exception while stalled
    BranchTarget = 32'h0000_0020;
    step(); chk("br_to_20", PCResult, 32'h0000_0020);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("exc_pc", PCResult, 32'h8000_0180);
    chk("exc_epc", EPC, 32'h0000_0020);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("exc_hold_pc", PCResult, 32'h8000_0180);
    chk("exc_hold_epc", EPC, 32'h0000_0020);

    // call then return
    BranchTarget = 32'h0000_0100;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk("br_to_100", PCResult, 32'h0000_0100);
    JumpTarget = 32'h0000_0200;
    set_ctl(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); chk("call_pc", PCResult, 32'h0000_0200);
    chk_flags("call", !RAS_EN, 1'b0);
    BranchTarget = 32'h0000_0210;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk("br_to_210", PCResult, 32'h0000_0210);
    JumpTarget = 32'h0000_0999;
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(); chk("ret_pc", PCResult, RAS_EN ? 32'h0000_0108 : 32'h0000_0998);
    chk_flags("ret", 1'b1, 1'b0);

    // five calls overflow a four-entry stack, then five returns
    BranchTarget = 32'h0000_1000;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk("br_to_1000", PCResult, 32'h0000_1000);
    set_ctl(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      call_pc[k] = 32'h0000_1000 * (k + 1);
      JumpTarget = 32'h0000_1000 * (k + 2);
      step();
      chk($sformatf("call%0d_pc", k), PCResult, 32'h0000_1000 * (k + 2));
      chk_flags($sformatf("call%0d", k), !RAS_EN, RAS_EN && (k >= 3));
    end
    JumpTarget = 32'h0000_7000;
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int r = 0; r < 5; r++) begin
      step();
      exp_pc = (RAS_EN && r < 4) ? call_pc[4 - r] + 32'h8 : 32'h0000_7000;
      chk($sformatf("ret%0d_pc", r), PCResult, exp_pc);
      chk_flags($sformatf("ret%0d", r), !RAS_EN || (r >= 3), 1'b0);
    end

    // link+return rewrites the top entry
    JumpTarget = 32'h0000_8000;
    set_ctl(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); chk("call8_pc", PCResult, 32'h0000_8000);
    JumpTarget = 32'h0000_9000;
    set_ctl(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); chk("swap_pc", PCResult, RAS_EN ? 32'h0000_7008 : 32'h0000_9000);
    chk_flags("swap", !RAS_EN, 1'b0);
    JumpTarget = 32'h0000_A000;
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(); chk("swap_ret_pc", PCResult, RAS_EN ? 32'h0000_8008 : 32'h0000_A000);
    chk_flags("swap_ret", 1'b1, 1'b0);

    // reset mid-call discards the stack
    JumpTarget = 32'h0000_B000;
    set_ctl(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); chk("call_b_pc", PCResult, 32'h0000_B000);
    Reset = 1'b1;
    step(); chk("midrst_pc", PCResult, 32'h0000_0000);
    chk_flags("midrst", 1'b1, 1'b0);
    Reset = 1'b0;
    JumpTarget = 32'h0000_C000;
    set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(); chk("ret_after_rst", PCResult, 32'h0000_C000);

    // address wrap and target alignment
    BranchTarget = 32'hFFFF_FFFC;
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk("br_to_top", PCResult, 32'hFFFF_FFFC);
    chk("top_plus4", PCPlus4, 32'h0000_0000);
    BranchTaken = 1'b0;
    step(); chk("wrap", PCResult, 32'h0000_0000);
    BranchTaken = 1'b1; BranchTarget = 32'h0000_0043;
    step(); chk("align", PCResult, 32'h0000_0040);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
